sonar_filter: RTL

Downstream consumer of the sonar ranging block. Takes each 8-bit distance sample and its one-cycle valid pulse, and keeps a moving average over the last 2^LOG2_DEPTH samples in a ring buffer with a running sum. Emits the filtered distance plus a hysteresis proximity flag. Feeds the peripheral register bank and the motor-stop logic.

---
 rtl/sonar_pkg.sv | 13 +
 rtl/sonar_ring_sum.sv | 66 ++++++
 rtl/sonar_filter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar moving-average filter.
package sonar_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] ZERO_SAMPLE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/sonar_ring_sum.sv
// Ring buffer of the last 2^LOG2_DEPTH samples with a running sum.
module sonar_ring_sum
    import sonar_pkg::*;
#(
    parameter int LOG2_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           wr,
    input  logic [SAMPLE_W-1:0]            din,
    output logic [SAMPLE_W+LOG2_DEPTH-1:0] sum_next,
    output logic                           full,
    output logic                           fill_last
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = SAMPLE_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);

    logic [SAMPLE_W-1:0]   mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [SAMPLE_W-1:0]   old;

    always_comb begin
        full      = (count_q == CNT_FULL);
        fill_last = (count_q == CNT_FULL - 1'b1);
        // While filling, the slot being written holds nothing counted in the sum
        old       = full ? mem_q[wr_ptr_q] : '0;
        sum_next  = sum_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (wr) begin
            sum_next = sum_q + SW'(din) - SW'(old);
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = full ? count_q : count_q + 1'b1;
        end
        sum_d = sum_next;
        if (clear) begin
            sum_d    = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clear) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sonar_filter.sv
// Sonar distance moving-average filter with hysteresis proximity flag.
// Optional zero-sample rejection and flush: define SONAR_FILT_ZERO_REJECT_EN.
module sonar_filter
    import sonar_pkg::*;
#(
    parameter int LOG2_DEPTH = 2,
    parameter int ZERO_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] dist_in,
    input  logic                valid_in,
    input  logic [SAMPLE_W-1:0] thresh_lo,
    input  logic [SAMPLE_W-1:0] thresh_hi,
    output logic [SAMPLE_W-1:0] dist_avg,
    output logic                avg_valid,
    output logic                primed,
    output logic                near,
    output logic                out_of_range
);

    localparam int SW = SAMPLE_W + LOG2_DEPTH;

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] dist_avg_q, dist_avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                near_q, near_d;
    logic                accept, wr, flush, clear, pulse;
    logic [SW-1:0]       sum_next;
    logic                full, fill_last;
    logic [SAMPLE_W-1:0] avg_new;

`ifdef SONAR_FILT_ZERO_REJECT_EN
    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    logic [ZW-1:0] zcnt_q, zcnt_d;
    logic          oor_q, oor_d;
    logic          is_zero;

    always_comb begin
        is_zero = (dist_in == ZERO_SAMPLE);
        wr      = accept & ~is_zero;
        zcnt_d  = zcnt_q;
        flush   = 1'b0;
        if (!en) begin
            zcnt_d = '0;
        end else if (accept) begin
            if (!is_zero) begin
                zcnt_d = '0;
            end else if (zcnt_q < ZW'(ZERO_LIMIT)) begin
                // Flush only on the zero that reaches the limit
                zcnt_d = zcnt_q + 1'b1;
                flush  = (zcnt_d == ZW'(ZERO_LIMIT));
            end
        end
        oor_d = oor_q;
        if (!en) oor_d = 1'b0;
        else if (flush) oor_d = 1'b1;
        else if (pulse) oor_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zcnt_q <= '0;
            oor_q  <= 1'b0;
        end else begin
            zcnt_q <= zcnt_d;
            oor_q  <= oor_d;
        end
    end

    assign out_of_range = oor_q;
`else
    always_comb begin
        wr    = accept;
        flush = 1'b0;
    end

    assign out_of_range = 1'b0;
`endif

    sonar_ring_sum #(
        .LOG2_DEPTH(LOG2_DEPTH)
    ) u_ring (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr       (wr),
        .din      (dist_in),
        .sum_next (sum_next),
        .full     (full),
        .fill_last(fill_last)
    );

    always_comb begin
        accept      = en & valid_in & (state_q != ST_IDLE);
        clear       = ~en | flush;
        pulse       = wr & (full | fill_last);
        avg_new     = sum_next[SW-1:LOG2_DEPTH];
        state_d     = state_q;
        dist_avg_d  = dist_avg_q;
        avg_valid_d = 1'b0;
        near_d      = near_q;
        if (!en) begin
            state_d    = ST_IDLE;
            dist_avg_d = '0;
            near_d     = 1'b0;
        end else if (flush) begin
            state_d     = ST_FILL;
            dist_avg_d  = '0;
            avg_valid_d = 1'b1;
            near_d      = 1'b0;
        end else begin
            if (state_q == ST_IDLE) state_d = ST_FILL;
            if (pulse) begin
                state_d     = ST_RUN;
                dist_avg_d  = avg_new;
                avg_valid_d = 1'b1;
                if (avg_new < thresh_lo) near_d = 1'b1;
                else if (avg_new > thresh_hi) near_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dist_avg_q  <= '0;
            avg_valid_q <= 1'b0;
            near_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dist_avg_q  <= dist_avg_d;
            avg_valid_q <= avg_valid_d;
            near_q      <= near_d;
        end
    end

    assign dist_avg  = dist_avg_q;
    assign avg_valid = avg_valid_q;
    assign near      = near_q;
    assign primed    = (state_q == ST_RUN);

endmodule
